led_matrix_scanner: RTL and testbench
=====================================

# led_matrix_scanner

Autonomous refresh controller for the iceFUN 8x4 LED matrix. It sits downstream of the stack machine's I/O decode and replaces direct CPU writes to the row and column registers. The CPU writes four column bitmaps into a back buffer and requests a swap. The block then time-multiplexes the front buffer onto the matrix, with per-frame buffer swap, 4-bit PWM brightness and a sticky frame flag. The top level inverts `led_row` and `led_column` onto the active-low pins.

## Interface
- `CPU_WIDTH`, 12, CPU data width; `rd_data`/`wr_data` width.
- `DIV_BITS`, 16, log2 of clocks per column slot; minimum 4; benches use 4.
- `clock`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-low.
- `sel`  in  1  I/O region select, qualified by the top's address decode.
- `write`  in  1  CPU write strobe; a write takes effect only when `sel & write`.
- `addr`  in  3  register index.
- `wr_data`  in  CPU_WIDTH  write data.
- `rd_data`  out  CPU_WIDTH  combinational read data; 0 when `sel`=0.
- `led_row`  out  8  active-high row drive.
- `led_column`  out  4  active-high one-hot column drive.
- `frame_tick`  out  1  one-cycle pulse at each frame boundary.

## Operation
- Register map. Unused read bits return 0.
  - 0–3: BACK[n], bits [7:0], column n bitmap in the back buffer. Read returns the back buffer.
  - 4: CTRL.
    - bit0 `enable`, R/W.
    - bit1 `swap_pending`. Writing 1 sets it; writing 0 has no effect; read returns the pending state.
  - 5: BRIGHT, bits [3:0], R/W.
  - 6: STATUS.
    - bit0 `frame_flag`, write 1 to clear.
    - bits [2:1] `col`, read-only.
  - 7: reserved. Reads 0; writes are ignored.
- Reset values:
  - BACK, FRONT, `enable`, `swap_pending`, `frame_flag`, `col`, slot counter `cnt`: 0.
  - BRIGHT = 4'hF.
  - All outputs: 0.
- Scan states:
  - IDLE (`enable`=0):
    - `cnt`=0, `col`=0.
    - `led_row`=0, `led_column`=0, no `frame_tick`.
  - SCAN (`enable`=1):
    - `cnt` (DIV_BITS wide) increments every cycle.
    - When `cnt` = all-ones, it wraps to 0 and `col` advances (3 wraps to 0).
- Frame boundary: the cycle where `cnt` = all-ones and `col` = 3. On that clock edge:
  - `frame_tick` is registered high for the following cycle only.
  - `frame_flag` is set.
  - If `swap_pending` was 1 before this edge, FRONT <= BACK for all four columns and `swap_pending` is cleared.
- Drive:
  - `phase` = `cnt`[DIV_BITS-1:DIV_BITS-4].
  - When `phase` <= BRIGHT: `led_row` = FRONT[`col`] and `led_column` = 1<<`col`.
  - Otherwise both are 0.
  - BRIGHT=15 gives 16/16 on-time; BRIGHT=0 gives 1/16.
- Outputs are registered, computed from next-state values, so they align with `col`/`cnt` as seen on STATUS.
- Clearing `enable` during SCAN:
  - Next cycle is IDLE: outputs 0, `col`/`cnt` zeroed.
  - A pending swap stays pending.
- Setting `enable` starts at `col`=0, `cnt`=0.
- Reset mid-scan forces all reset values on the next edge, regardless of other inputs.

## Timing
- Register write: visible on `rd_data` the cycle after the write edge.
- Column slot = 2^DIV_BITS cycles. Frame = 4·2^DIV_BITS cycles. `frame_tick` period = 4·2^DIV_BITS.
- First `frame_tick` after enable: the cycle after edge number 4·2^DIV_BITS.
- Swap latency: swap occurs at the first frame boundary strictly after the write that set `swap_pending`. A swap request written on the boundary cycle itself is deferred one frame.
- BACK write on a boundary cycle with a swap pending:
  - FRONT receives the pre-write BACK value.
  - BACK holds the new value.
- STATUS write-1-clear and frame-boundary set on the same edge: set wins, `frame_flag`=1.
- BRIGHT change takes effect on the next cycle's drive compare; no frame alignment.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with random bus activity.
  - All outputs 0.
  - Reads: addr5 = 0x00F, addr4 = 0, addr6 = 0.
- Basic scan, DIV_BITS=4:
  - Stimulus: write BACK = {0x81,0x42,0x24,0x18}, CTRL=0x3.
  - Required: first frame shows `led_row`=0 for all 64 cycles.
  - Required: at the boundary, FRONT loads and `frame_tick` pulses once.
  - Required: the next frame shows `led_column` 1,2,4,8 for 16 cycles each, with `led_row` 0x81,0x42,0x24,0x18.
- Brightness:
  - BRIGHT=3: each slot drives rows for exactly 4 of 16 cycles (`phase` 0–3), otherwise 0.
  - BRIGHT=0: 1 of 16 cycles.
- Deferred swap and simultaneous events:
  - Write CTRL=0x3 on the boundary cycle: FRONT unchanged at that boundary, updated at the next one.
  - STATUS write 0x1 on the boundary cycle: `frame_flag` reads 1.
- Disable mid-frame:
  - Clear `enable` at `col`=2, `cnt`=7: next cycle outputs 0, STATUS `col`=0, `swap_pending` retained.
  - Re-enable: scan restarts at `col`=0 and the pending swap happens at the first boundary.
- Reset mid-scan with `swap_pending`=1: all state returns to reset values and no swap occurs afterwards.

Source files
------------

// File: rtl/led_matrix_scanner.sv
// Refresh controller for the 8x4 LED matrix. It double-buffers the column bitmaps,
// drives one column at a time with 4-bit PWM brightness, and flags each frame boundary.
module led_matrix_scanner #(
  parameter int unsigned CPU_WIDTH = 12,
  parameter int unsigned DIV_BITS  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sel,
  input  logic                 write,
  input  logic [2:0]           addr,
  input  logic [CPU_WIDTH-1:0] wr_data,
  output logic [CPU_WIDTH-1:0] rd_data,
  output logic [7:0]           led_row,
  output logic [3:0]           led_column,
  output logic                 frame_tick
);

  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned ROW_W    = 8;
  localparam int unsigned COL_W    = 2;
  localparam int unsigned BRIGHT_W = 4;

  localparam logic [2:0]          ADDR_CTRL   = 3'd4;
  localparam logic [2:0]          ADDR_BRIGHT = 3'd5;
  localparam logic [2:0]          ADDR_STATUS = 3'd6;
  localparam logic [COL_W-1:0]    LAST_COL    = COL_W'(NUM_COLS - 1);
  localparam logic [BRIGHT_W-1:0] BRIGHT_RST  = BRIGHT_W'(4'hF);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  scan_state_t         state, state_nxt;
  logic [ROW_W-1:0]    back_q  [NUM_COLS];
  logic [ROW_W-1:0]    back_nxt[NUM_COLS];
  logic [ROW_W-1:0]    front_q  [NUM_COLS];
  logic [ROW_W-1:0]    front_nxt[NUM_COLS];
  logic                swap_pending_q, swap_pending_nxt;
  logic                frame_flag_q, frame_flag_nxt;
  logic [BRIGHT_W-1:0] bright_q, bright_nxt;
  logic [COL_W-1:0]    col_q, col_nxt;
  logic [DIV_BITS-1:0] cnt_q, cnt_nxt;
  logic [BRIGHT_W-1:0] phase_nxt;
  logic [ROW_W-1:0]    led_row_nxt;
  logic [NUM_COLS-1:0] led_column_nxt;
  logic                frame_tick_nxt;
  logic                wr_en;
  logic                boundary;
  logic                unused_wr_bits;

  assign wr_en          = sel & write;
  assign boundary       = (state == SCAN) && (cnt_q == '1) && (col_q == LAST_COL);
  assign unused_wr_bits = ^wr_data[CPU_WIDTH-1:ROW_W];

  // Next-state: buffer swap, register writes, scan counters, then the drive pattern
  always_comb begin
    state_nxt        = state;
    back_nxt         = back_q;
    front_nxt        = front_q;
    swap_pending_nxt = swap_pending_q;
    frame_flag_nxt   = frame_flag_q;
    bright_nxt       = bright_q;
    col_nxt          = col_q;
    cnt_nxt          = cnt_q;
    phase_nxt        = '0;
    led_row_nxt      = '0;
    led_column_nxt   = '0;
    frame_tick_nxt   = 1'b0;

    // The swap takes the pre-write BACK, and a swap request on this edge waits a frame
    if (boundary) begin
      if (swap_pending_q) begin
        front_nxt = back_q;
      end
      swap_pending_nxt = 1'b0;
    end

    if (wr_en) begin
      case (addr)
        3'd0, 3'd1, 3'd2, 3'd3: back_nxt[addr[1:0]] = wr_data[ROW_W-1:0];
        ADDR_CTRL: begin
          state_nxt = wr_data[0] ? SCAN : IDLE;
          if (wr_data[1]) begin
            swap_pending_nxt = 1'b1;
          end
        end
        ADDR_BRIGHT: bright_nxt = wr_data[BRIGHT_W-1:0];
        ADDR_STATUS: begin
          if (wr_data[0]) begin
            frame_flag_nxt = 1'b0;
          end
        end
        default: ;
      endcase
    end

    // A boundary set wins over a write-1-clear on the same edge
    if (boundary) begin
      frame_flag_nxt = 1'b1;
    end

    if ((state == SCAN) && (state_nxt == SCAN)) begin
      cnt_nxt = cnt_q + DIV_BITS'(1);
      if (cnt_q == '1) begin
        col_nxt = col_q + COL_W'(1);
      end
    end else begin
      cnt_nxt = '0;
      col_nxt = '0;
    end

    phase_nxt = cnt_nxt[DIV_BITS-1 -: BRIGHT_W];
    if (state_nxt == SCAN) begin
      frame_tick_nxt = boundary;
      if (phase_nxt <= bright_nxt) begin
        led_row_nxt    = front_nxt[col_nxt];
        led_column_nxt = NUM_COLS'(1) << col_nxt;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= IDLE;
      swap_pending_q <= 1'b0;
      frame_flag_q   <= 1'b0;
      bright_q       <= BRIGHT_RST;
      col_q          <= '0;
      cnt_q          <= '0;
      led_row        <= '0;
      led_column     <= '0;
      frame_tick     <= 1'b0;
      for (int i = 0; i < NUM_COLS; i++) begin
        back_q[i]  <= '0;
        front_q[i] <= '0;
      end
    end else begin
      state          <= state_nxt;
      swap_pending_q <= swap_pending_nxt;
      frame_flag_q   <= frame_flag_nxt;
      bright_q       <= bright_nxt;
      col_q          <= col_nxt;
      cnt_q          <= cnt_nxt;
      led_row        <= led_row_nxt;
      led_column     <= led_column_nxt;
      frame_tick     <= frame_tick_nxt;
      back_q         <= back_nxt;
      front_q        <= front_nxt;
    end
  end

  // Combinational register read; the bus floats to zero when not selected
  always_comb begin
    rd_data = '0;
    if (sel) begin
      case (addr)
        3'd0, 3'd1, 3'd2, 3'd3: rd_data[ROW_W-1:0] = back_q[addr[1:0]];
        ADDR_CTRL:   rd_data[1:0] = {swap_pending_q, state == SCAN};
        ADDR_BRIGHT: rd_data[BRIGHT_W-1:0] = bright_q;
        ADDR_STATUS: rd_data[2:0] = {col_q, frame_flag_q};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner (DIV_BITS=4). It compares the DUT against a frame-position model on
// every cycle and runs directed scenarios with hand-computed expectations.
module tb_led_matrix_scanner;

  logic        clock;
  logic        reset;
  logic        sel;
  logic        write;
  logic [2:0]  addr;
  logic [11:0] wr_data;
  logic [11:0] rd_data;
  logic [7:0]  led_row;
  logic [3:0]  led_column;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  // Model state: scan position is cycles since the scan started (64 per frame)
  logic [7:0] m_back [4];
  logic [7:0] m_front[4];
  logic       m_en     = 1'b0;
  logic       m_pend   = 1'b0;
  logic       m_flag   = 1'b0;
  logic [3:0] m_bright = 4'hF;
  int         m_pos    = 0;
  logic [7:0] e_row    = '0;
  logic [3:0] e_col    = '0;
  logic       e_tick   = 1'b0;

  led_matrix_scanner #(.CPU_WIDTH(12), .DIV_BITS(4)) dut (
    .clock(clock), .reset(reset), .sel(sel), .write(write), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .led_row(led_row),
    .led_column(led_column), .frame_tick(frame_tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin : model
    logic       bnd;
    logic       nen;
    logic [1:0] c;
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        m_back[i]  = '0;
        m_front[i] = '0;
      end
      m_en = 1'b0; m_pend = 1'b0; m_flag = 1'b0; m_bright = 4'hF; m_pos = 0;
      e_row = '0; e_col = '0; e_tick = 1'b0;
    end else begin
      bnd = m_en && (m_pos % 64 == 63);
      nen = m_en;
      if (bnd) begin
        if (m_pend) for (int i = 0; i < 4; i++) m_front[i] = m_back[i];
        m_pend = 1'b0;
      end
      if (sel && write) begin
        if (addr < 3'd4) m_back[addr[1:0]] = wr_data[7:0];
        else if (addr == 3'd4) begin
          nen = wr_data[0];
          if (wr_data[1]) m_pend = 1'b1;
        end
        else if (addr == 3'd5) m_bright = wr_data[3:0];
        else if (addr == 3'd6 && wr_data[0]) m_flag = 1'b0;
      end
      if (bnd) m_flag = 1'b1;
      m_pos  = (m_en && nen) ? m_pos + 1 : 0;
      m_en   = nen;
      e_tick = bnd && nen;
      c      = 2'((m_pos / 16) % 4);
      if (nen && ((m_pos % 16) <= int'(m_bright))) begin
        e_row = m_front[c];
        e_col = 4'b0001 << c;
      end else begin
        e_row = '0;
        e_col = '0;
      end
    end
  end

  function automatic logic [11:0] m_read(input logic [2:0] a);
    logic [1:0] c;
    c = m_en ? 2'((m_pos / 16) % 4) : 2'd0;
    case (a)
      3'd0, 3'd1, 3'd2, 3'd3: return {4'h0, m_back[a[1:0]]};
      3'd4: return {10'h0, m_pend, m_en};
      3'd5: return {8'h0, m_bright};
      3'd6: return {9'h0, c, m_flag};
      default: return 12'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock and compare the registered outputs against the model
  task automatic step();
    @(posedge clock);
    #1;
    chk("led_row", 32'(led_row), 32'(e_row));
    chk("led_column", 32'(led_column), 32'(e_col));
    chk("frame_tick", 32'(frame_tick), 32'(e_tick));
    if (!sel) chk("rd_idle", 32'(rd_data), 32'h0);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [11:0] d);
    sel = 1'b1; write = 1'b1; addr = a; wr_data = d;
    step();
    sel = 1'b0; write = 1'b0;
  endtask

  task automatic rd_lit(input logic [2:0] a, input logic [11:0] exp, input string name);
    sel = 1'b1; write = 1'b0; addr = a;
    #1;
    chk(name, 32'(rd_data), 32'(exp));
    sel = 1'b0;
  endtask

  task automatic rd_all_model();
    for (int a = 0; a < 8; a++) begin
      sel = 1'b1; write = 1'b0; addr = 3'(a);
      #1;
      chk("rd_model", 32'(rd_data), 32'(m_read(3'(a))));
    end
    sel = 1'b0;
  endtask

  task automatic wait_pos(input int target);
    bit found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (m_en && (m_pos % 64 == target)) found = 1'b1;
      else step();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_pos: got timeout expected position %0d", target);
    end
  endtask

  task automatic count_on_slot(output int on);
    on = 0;
    for (int i = 0; i < 16; i++) begin
      if (led_column != 4'h0) on++;
      step();
    end
  endtask

  initial begin : stim
    int ticks;
    int on;
    reset = 1'b0; sel = 1'b0; write = 1'b0; addr = '0; wr_data = '0;

    // Reset with random bus activity
    repeat (2) begin
      sel = 1'($urandom_range(0, 1)); write = 1'($urandom_range(0, 1));
      addr = 3'($urandom_range(0, 7)); wr_data = 12'($urandom);
      step();
    end
    sel = 1'b0; write = 1'b0;
    chk("rst_row", 32'(led_row), 32'h0);
    chk("rst_col", 32'(led_column), 32'h0);
    reset = 1'b1;
    rd_lit(3'd5, 12'h00F, "rst_bright");
    rd_lit(3'd4, 12'h000, "rst_ctrl");
    rd_lit(3'd6, 12'h000, "rst_status");

    // Basic scan: first frame dark, swap at boundary, then the pattern
    bus_write(3'd0, 12'h081); bus_write(3'd1, 12'h042);
    bus_write(3'd2, 12'h024); bus_write(3'd3, 12'h018);
    rd_lit(3'd1, 12'h042, "back1");
    bus_write(3'd4, 12'h003);
    chk("row_first_frame", 32'(led_row), 32'h0);
    ticks = 0; on = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (frame_tick) ticks++;
      if (i < 63 && led_row != 8'h0) on++;
    end
    chk("ticks_frame1", 32'(ticks), 32'd1);
    chk("dark_frame1", 32'(on), 32'd0);
    chk("row_col0", 32'(led_row), 32'h81);
    chk("column_col0", 32'(led_column), 32'h1);
    repeat (21) step();
    chk("row_col1", 32'(led_row), 32'h42);
    chk("column_col1", 32'(led_column), 32'h2);
    rd_lit(3'd6, 12'h003, "status_col1_flag");
    bus_write(3'd6, 12'h001);
    rd_lit(3'd6, 12'h002, "status_cleared");
    rd_all_model();

    // Brightness
    bus_write(3'd5, 12'h003);
    wait_pos(0);
    count_on_slot(on);
    chk("bright3_on", 32'(on), 32'd4);
    bus_write(3'd5, 12'h000);
    wait_pos(0);
    count_on_slot(on);
    chk("bright0_on", 32'(on), 32'd1);
    bus_write(3'd5, 12'h00F);

    // Swap request and status clear on the boundary cycle
    bus_write(3'd0, 12'h011); bus_write(3'd1, 12'h022);
    bus_write(3'd2, 12'h033); bus_write(3'd3, 12'h044);
    wait_pos(63);
    bus_write(3'd4, 12'h003);
    chk("deferred_row", 32'(led_row), 32'h81);
    rd_lit(3'd4, 12'h003, "deferred_pending");
    wait_pos(63);
    bus_write(3'd6, 12'h001);
    rd_lit(3'd6, 12'h001, "flag_set_wins");
    chk("swapped_row", 32'(led_row), 32'h11);

    // BACK write on a swapping boundary
    bus_write(3'd0, 12'h099);
    bus_write(3'd4, 12'h003);
    wait_pos(63);
    bus_write(3'd0, 12'h05A);
    chk("prewrite_front", 32'(led_row), 32'h99);
    rd_lit(3'd0, 12'h05A, "back_new");
    rd_all_model();

    // Disable mid-frame keeps the pending swap; re-enable restarts the scan
    bus_write(3'd4, 12'h003);
    wait_pos(39);
    bus_write(3'd4, 12'h000);
    chk("dis_row", 32'(led_row), 32'h0);
    chk("dis_col", 32'(led_column), 32'h0);
    rd_lit(3'd6, 12'h001, "dis_status");
    rd_lit(3'd4, 12'h002, "dis_pending");
    repeat (5) step();
    bus_write(3'd4, 12'h001);
    rd_lit(3'd4, 12'h003, "reen_ctrl");
    chk("reen_column", 32'(led_column), 32'h1);
    repeat (64) step();
    chk("reen_swap_row", 32'(led_row), 32'h5A);
    rd_lit(3'd4, 12'h001, "reen_no_pending");

    // Reset mid-scan with a swap pending
    bus_write(3'd0, 12'h077);
    bus_write(3'd4, 12'h003);
    repeat (10) step();
    reset = 1'b0; sel = 1'b1; write = 1'b1; addr = 3'd4; wr_data = 12'h003;
    step();
    sel = 1'b0; write = 1'b0; reset = 1'b1;
    chk("mid_rst_row", 32'(led_row), 32'h0);
    rd_lit(3'd4, 12'h000, "mid_rst_ctrl");
    rd_lit(3'd0, 12'h000, "mid_rst_back0");
    rd_lit(3'd5, 12'h00F, "mid_rst_bright");
    rd_lit(3'd6, 12'h000, "mid_rst_status");
    bus_write(3'd4, 12'h001);
    repeat (140) step();
    chk("no_swap_row", 32'(led_row), 32'h0);
    rd_lit(3'd4, 12'h001, "no_swap_ctrl");
    rd_all_model();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
